// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: per-register result-latency tracking, load-use stall
// generation, operand forwarding selects, memory-miss freeze and
// saturating performance counters.
module hazard_scoreboard #(
  parameter  int NUM_SRC = 2,
  parameter  int NUM_FWD = 2,
  parameter  int MAX_LAT = 4,
  parameter  int CNT_W   = 16,
  localparam int LAT_W   = $clog2(MAX_LAT + 1),
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_we,
  input  logic [4:0]               id_rd,
  input  logic [LAT_W-1:0]         id_lat,
  input  logic [5*NUM_SRC-1:0]     id_src_idx,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [NUM_SRC-1:0]       id_src_is_store,
  input  logic [5*NUM_FWD-1:0]     fwd_rd,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic                     inst_req,
  input  logic                     inst_resp,
  input  logic                     data_req,
  input  logic                     data_resp,
  input  logic                     perf_clr,
  output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
  output logic                     stall_front,
  output logic                     bubble,
  output logic                     freeze,
  output logic [CNT_W-1:0]         hazard_stall_cnt,
  output logic [CNT_W-1:0]         freeze_cnt,
  output logic [CNT_W-1:0]         miss_events
);

  typedef enum logic {
    ST_RUN,
    ST_FREEZE
  } state_t;

  logic [LAT_W-1:0] sb_q [1:31];
  logic [LAT_W-1:0] sb_d [1:31];
  logic [LAT_W-1:0] sb_view [0:31];
  logic [LAT_W-1:0] lat_clamped;
  logic [NUM_SRC-1:0] src_haz;
  logic             hazard;
  logic             advance;
  logic             fwd_found;
  logic             miss_inc;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hsc_q, hsc_d;
  logic [CNT_W-1:0] frz_q, frz_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Memory handshakes stall the whole pipe with no added latency.
  always_comb begin
    freeze = (inst_req & ~inst_resp) | (data_req & ~data_resp);
  end

  // Scoreboard view with x0 hard-wired to "ready".
  always_comb begin
    sb_view[0] = '0;
    for (int unsigned r = 1; r < 32; r++) sb_view[r] = sb_q[r];
  end

  // Per-source RAW hazard; store data with one cycle left is exempt since it is consumed in MEM.
  always_comb begin
    src_haz = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      src_haz[s] = id_valid & id_src_used[s]
                 & (id_src_idx[s*5 +: 5] != 5'd0)
                 & (sb_view[id_src_idx[s*5 +: 5]] != '0)
                 & ~(id_src_is_store[s] & (sb_view[id_src_idx[s*5 +: 5]] == LAT_W'(1)));
    end
  end

  // Stall/bubble/advance decode.
  always_comb begin
    hazard      = |src_haz;
    stall_front = hazard | freeze;
    bubble      = hazard & ~freeze;
    advance     = id_valid & ~stall_front & ~freeze;
    lat_clamped = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
  end

  // Scoreboard next state: hold on freeze, else count down; an advancing write overrides the countdown.
  always_comb begin
    for (int unsigned r = 1; r < 32; r++) begin
      sb_d[r] = sb_q[r];
      if (!freeze) begin
        if (sb_q[r] != '0) sb_d[r] = sb_q[r] - LAT_W'(1);
        if (advance && id_we && (id_rd == 5'(r))) sb_d[r] = lat_clamped;
      end
    end
  end

  // Forwarding select: youngest matching writing stage wins.
  always_comb begin
    fwd_sel   = '0;
    fwd_found = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      fwd_found = 1'b0;
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!fwd_found && fwd_we[k] && (fwd_rd[k*5 +: 5] != 5'd0)
            && (fwd_rd[k*5 +: 5] == id_src_idx[s*5 +: 5])) begin
          fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
          fwd_found                 = 1'b1;
        end
      end
    end
  end

  // Miss FSM: counts entries into the frozen state.
  always_comb begin
    state_d  = state_q;
    miss_inc = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d  = ST_FREEZE;
          miss_inc = 1'b1;
        end
      end
      ST_FREEZE: begin
        if (!freeze) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    hsc_d  = bubble   ? sat_inc(hsc_q)  : hsc_q;
    frz_d  = freeze   ? sat_inc(frz_q)  : frz_q;
    miss_d = miss_inc ? sat_inc(miss_q) : miss_q;
    if (perf_clr) begin
      hsc_d  = '0;
      frz_d  = '0;
      miss_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < 32; r++) sb_q[r] <= '0;
      state_q <= ST_RUN;
      hsc_q   <= '0;
      frz_q   <= '0;
      miss_q  <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) sb_q[r] <= sb_d[r];
      state_q <= state_d;
      hsc_q   <= hsc_d;
      frz_q   <= frz_d;
      miss_q  <= miss_d;
    end
  end

  assign hazard_stall_cnt = hsc_q;
  assign freeze_cnt       = frz_q;
  assign miss_events      = miss_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic          id_we;
  logic [4:0]    id_rd;
  logic [2:0]    id_lat;
  logic [9:0]    id_src_idx;
  logic [1:0]    id_src_used;
  logic [1:0]    id_src_is_store;
  logic [9:0]    fwd_rd;
  logic [1:0]    fwd_we;
  logic          inst_req, inst_resp, data_req, data_resp;
  logic          perf_clr;
  logic [3:0]    fwd_sel;
  logic          stall_front, bubble, freeze;
  logic [CW-1:0] hazard_stall_cnt, freeze_cnt, miss_events;

  int n_chk  = 0;
  int n_fail = 0;
  int n;
  int stalls;
  int bad;

  hazard_scoreboard #(.NUM_SRC(2), .NUM_FWD(2), .MAX_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
    .id_lat(id_lat), .id_src_idx(id_src_idx), .id_src_used(id_src_used),
    .id_src_is_store(id_src_is_store), .fwd_rd(fwd_rd), .fwd_we(fwd_we),
    .inst_req(inst_req), .inst_resp(inst_resp), .data_req(data_req),
    .data_resp(data_resp), .perf_clr(perf_clr), .fwd_sel(fwd_sel),
    .stall_front(stall_front), .bubble(bubble), .freeze(freeze),
    .hazard_stall_cnt(hazard_stall_cnt), .freeze_cnt(freeze_cnt),
    .miss_events(miss_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_we = 0; id_rd = 0; id_lat = 0;
    id_src_idx = 0; id_src_used = 0; id_src_is_store = 0;
    fwd_rd = 0; fwd_we = 0;
    inst_req = 0; inst_resp = 0; data_req = 0; data_resp = 0;
    perf_clr = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    idle();
    id_valid = 1; id_we = 1; id_rd = rd; id_lat = lat;
  endtask

  task automatic consume(input logic [4:0] src, input logic st, input int slot);
    idle();
    id_valid = 1;
    id_src_idx[slot*5 +: 5] = src;
    id_src_used[slot]       = 1'b1;
    id_src_is_store[slot]   = st;
  endtask

  // Count consecutive bubble cycles of the instruction currently in ID (bounded).
  task automatic count_bubbles(output int cnt);
    cnt = 0;
    #1;
    while (bubble && cnt < 12) begin
      cnt++;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; idle();
    cyc(); cyc();
    rst = 0; #1;
    check_eq("rst_bubble", bubble, 0);
    check_eq("rst_stall", stall_front, 0);
    check_eq("rst_hsc", hazard_stall_cnt, 0);
    check_eq("rst_frz", freeze_cnt, 0);
    check_eq("rst_miss", miss_events, 0);
    inst_req = 1; #1;
    check_eq("rst_stall_follows_freeze", stall_front, 1);
    check_eq("rst_freeze_no_bubble", bubble, 0);
    idle(); #1;

    // Load-use, latency 1
    issue(5, 1); #1;
    check_eq("lu_issue_nostall", stall_front, 0);
    cyc();
    consume(5, 0, 0); #1;
    check_eq("lu_bubble", bubble, 1);
    check_eq("lu_stall", stall_front, 1);
    cyc();
    check_eq("lu_released", bubble, 0);
    check_eq("lu_released_stall", stall_front, 0);
    cyc(); idle(); #1;
    check_eq("lu_hsc", hazard_stall_cnt, 1);

    // Long latency on source slot 1
    issue(7, 4); cyc();
    consume(7, 0, 1);
    count_bubbles(n);
    check_eq("long_lat_bubbles", n, 4);
    cyc(); idle();

    // Clamp: latency 7 behaves as 4
    issue(7, 7); cyc();
    consume(7, 0, 0);
    count_bubbles(n);
    check_eq("clamp_bubbles", n, 4);
    cyc(); idle(); #1;
    check_eq("hsc_nine", hazard_stall_cnt, 9);

    // perf_clr beats the increment from a same-cycle bubble
    issue(7, 1); cyc();
    consume(7, 0, 0); perf_clr = 1; #1;
    check_eq("clr_cycle_bubble", bubble, 1);
    cyc(); perf_clr = 0; #1;
    check_eq("clr_hsc", hazard_stall_cnt, 0);
    check_eq("clr_keeps_sb", bubble, 0);
    cyc(); idle();

    // Forwarding priority
    fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; id_src_idx = {5'd5, 5'd5}; #1;
    check_eq("fwd_youngest", fwd_sel[1:0], 1);
    check_eq("fwd_youngest_s1", fwd_sel[3:2], 1);
    fwd_we = 2'b10; #1;
    check_eq("fwd_older", fwd_sel[1:0], 2);
    fwd_we = 2'b00; #1;
    check_eq("fwd_none", fwd_sel[1:0], 0);
    fwd_we = 2'b11; id_src_idx = {5'd5, 5'd0}; #1;
    check_eq("fwd_x0", fwd_sel[1:0], 0);
    fwd_rd = {5'd9, 5'd0}; fwd_we = 2'b11; id_src_idx = {5'd0, 5'd9}; #1;
    check_eq("fwd_rd0_skip", fwd_sel[1:0], 2);
    idle(); perf_clr = 1; cyc(); idle();

    // Freeze during a lat=4 hazard, frozen for 3 cycles from the 2nd bubble
    issue(7, 4); cyc();
    consume(7, 0, 0);
    stalls = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      data_req = (i >= 1 && i <= 3);
      #1;
      if (!stall_front) break;
      stalls++;
      if (freeze && bubble) bad++;
      cyc();
    end
    data_req = 0;
    check_eq("frz_total_stalls", stalls, 7);
    check_eq("frz_no_bubble", bad, 0);
    check_eq("frz_cnt", freeze_cnt, 3);
    check_eq("frz_miss", miss_events, 1);
    check_eq("frz_hsc", hazard_stall_cnt, 4);
    cyc(); idle();

    // Store-data exemption versus address use
    issue(3, 1); cyc();
    consume(3, 1, 0); #1;
    check_eq("store_data_nobubble", bubble, 0);
    cyc();
    issue(3, 1); cyc();
    consume(3, 0, 0);
    count_bubbles(n);
    check_eq("store_addr_bubbles", n, 1);
    cyc(); idle();

    // Reset in the middle of a lat=4 stall
    issue(7, 4); cyc();
    consume(7, 0, 0); #1;
    check_eq("rst_mid_bubble_pre", bubble, 1);
    cyc();
    rst = 1; cyc(); rst = 0; #1;
    check_eq("rst_mid_bubble", bubble, 0);
    check_eq("rst_mid_hsc", hazard_stall_cnt, 0);
    check_eq("rst_mid_frz", freeze_cnt, 0);
    check_eq("rst_mid_miss", miss_events, 0);
    cyc(); idle();

    // Counter saturation over one long freeze
    data_req = 1;
    for (int i = 0; i < 20; i++) cyc();
    check_eq("sat_frz", freeze_cnt, 15);
    check_eq("sat_miss_once", miss_events, 1);
    idle(); cyc();
    data_req = 1; cyc(); idle(); #1;
    check_eq("sat_miss_second", miss_events, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
